// File: rtl/seq_add_sub_if.sv
// seq_add_sub_if: operand/result bundle for the sequential adder/subtractor.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high. A source keeps valid and its payload stable until that
// edge. A sink never derives ready combinationally from valid.
//   input side : in_valid/in_ready, payload a, b, sub
//   output side: out_valid/out_ready, payload s, c_out, ovf, zero
//
// master modport: the operand producer / result consumer (testbench, upstream).
// slave  modport: the arithmetic block.
interface seq_add_sub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf, zero
  );
endinterface

// File: rtl/seq_add_sub.sv
// seq_add_sub: multi-cycle adder/subtractor. A WIDTH-bit operand pair is
// processed one DIGIT-bit slice per clock, LSB slice first, through a single
// DIGIT-bit adder. WIDTH must be a multiple of DIGIT; DIGIT == WIDTH gives a
// single-slice (one cycle) operation.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   bus       seq_add_sub_if slave: in_valid/in_ready + a, b, sub;
//             out_valid/out_ready + s, c_out, ovf, zero
//   state_dbg current FSM state (0 = IDLE, 1 = CALC, 2 = DONE)
module seq_add_sub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_add_sub_if.slave      bus,
  output logic [1:0]        state_dbg
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;      // operand A, shifted right one slice per cycle
  logic [WIDTH-1:0] b_q, b_d;      // operand B (pre-inverted for subtract), shifted likewise
  logic [WIDTH-1:0] r_q, r_d;      // partial result, slices enter at the MSB end
  logic [WIDTH-1:0] s_q, s_d;      // last completed result
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT:0]   slice_sum;
  logic [WIDTH-1:0] r_next;
  logic             last_slice;

  always_comb begin
    slice_sum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    // After NSLICE shifts the first slice has walked down to bit 0.
    r_next     = (r_q >> DIGIT) | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    last_slice = (cnt_q == CW'(NSLICE - 1));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    s_d     = s_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone marks the accept.
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        r_d     = r_next;
        carry_d = slice_sum[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (last_slice) begin
          s_d     = r_next;
          c_out_d = slice_sum[DIGIT];
          // Carry into the MSB recovered as a ^ b ^ sum at that bit position.
          ovf_d   = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice_sum[DIGIT-1] ^ slice_sum[DIGIT];
          zero_d  = (r_next == '0);
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs decode registered state only.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.s         = s_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// tb_seq_add_sub: self-checking bench for seq_add_sub. dut0 uses DIGIT = 4
// (four slices), dut1 uses DIGIT = WIDTH = 16 (one slice).
module tb_seq_add_sub;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_add_sub_if #(.WIDTH(W)) bus0 ();
  seq_add_sub_if #(.WIDTH(W)) bus1 ();
  logic [1:0] state0, state1;

  seq_add_sub #(.WIDTH(W), .DIGIT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .state_dbg(state0)
  );
  seq_add_sub #(.WIDTH(W), .DIGIT(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .state_dbg(state1)
  );

  // ---------------- scoreboard ----------------
  logic [W+2:0] exp_q[$];          // {s, c_out, ovf, zero}
  int           n_checks = 0;
  int           n_pass   = 0;
  longint       last_acc = 0;
  longint       prev_acc = 0;

  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         v;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + (W+1)'(sub);
    v    = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {full[W-1:0], full[W], v, (full[W-1:0] == '0)};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge with dut0 idle; returns at the negedge after accept.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    bus0.a        = a;
    bus0.b        = b;
    bus0.sub      = sub;
    bus0.in_valid = 1'b1;
    @(posedge clk);
    prev_acc = last_acc;
    last_acc = $time;
    @(negedge clk);
    bus0.in_valid = 1'b0;
    exp_q.push_back(model(a, b, sub));
  endtask

  // Waits (bounded) for out_valid on dut0; optionally scrambles inputs meanwhile.
  task automatic collect(input bit churn, output logic [W+2:0] got, output int lat,
                         output bit rdy_seen);
    lat      = 0;
    rdy_seen = 1'b0;
    while (bus0.out_valid !== 1'b1 && lat < 20) begin
      if (bus0.in_ready !== 1'b0) rdy_seen = 1'b1;
      if (churn) begin
        bus0.a        = W'($urandom_range(0, 16'hFFFF));
        bus0.b        = W'($urandom_range(0, 16'hFFFF));
        bus0.sub      = 1'($urandom_range(0, 1));
        bus0.in_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    if (bus0.in_ready !== 1'b0) rdy_seen = 1'b1;
    bus0.in_valid = 1'b0;
    if (lat >= 20) begin
      n_checks++;
      $display("FAIL out_valid_timeout waited=%0d cycles required<=%0d", lat, 4);
    end
    got = {bus0.s, bus0.c_out, bus0.ovf, bus0.zero};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.sub = 1'b0; bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.sub = 1'b0; bus1.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus0.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus0.in_ready); else n_pass++;
    n_checks++; if (bus0.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus0.out_valid); else n_pass++;
    n_checks++; if ({bus0.s, bus0.c_out, bus0.ovf, bus0.zero} !== '0)
      $display("FAIL reset_outputs got=%h exp=0", {bus0.s, bus0.c_out, bus0.ovf, bus0.zero}); else n_pass++;
    n_checks++; if (state0 !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state0); else n_pass++;
    n_checks++; if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0)
      $display("FAIL reset_dut1_hs got=%b%b exp=10", bus1.in_ready, bus1.out_valid); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    logic [W+2:0] got, exp;
    int lat;
    bit rdy;
    issue(16'h1234, 16'h0FFF, 1'b0);
    collect(1'b0, got, lat, rdy);
    exp = exp_q.pop_front();
    n_checks++; if (lat !== 4) $display("FAIL add_latency got=%0d exp=4", lat); else n_pass++;
    n_checks++; if (rdy !== 1'b0) $display("FAIL add_in_ready_busy got=%b exp=0", rdy); else n_pass++;
    n_checks++; if (got !== exp) $display("FAIL add_result got=%h exp=%h", got, exp); else n_pass++;
    n_checks++; if (got !== {16'h2233, 3'b000}) $display("FAIL add_literal got=%h exp=%h", got, {16'h2233, 3'b000}); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0)
      $display("FAIL add_back_to_idle got=%b%b exp=10", bus0.in_ready, bus0.out_valid); else n_pass++;
  endtask

  task automatic test_sub();
    logic [W-1:0] va[2] = '{16'h0000, 16'h0005};
    logic [W-1:0] vb[2] = '{16'h0002, 16'h0005};
    logic [W+2:0] lit[2] = '{{16'hFFFE, 3'b000}, {16'h0000, 3'b101}};
    logic [W+2:0] got, exp;
    int lat;
    bit rdy;
    for (int i = 0; i < 2; i++) begin
      issue(va[i], vb[i], 1'b1);
      collect(1'b0, got, lat, rdy);
      exp = exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL sub_result[%0d] got=%h exp=%h", i, got, exp); else n_pass++;
      n_checks++; if (got !== lit[i]) $display("FAIL sub_literal[%0d] got=%h exp=%h", i, got, lit[i]); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] va[2] = '{16'h7FFF, 16'h8000};
    logic [W-1:0] vb[2] = '{16'h0001, 16'h0001};
    logic         vs[2] = '{1'b0, 1'b1};
    logic [W+2:0] lit[2] = '{{16'h8000, 3'b010}, {16'h7FFF, 3'b110}};
    logic [W+2:0] got, exp;
    int lat;
    bit rdy;
    for (int i = 0; i < 2; i++) begin
      issue(va[i], vb[i], vs[i]);
      collect(1'b0, got, lat, rdy);
      exp = exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL ovf_result[%0d] got=%h exp=%h", i, got, exp); else n_pass++;
      n_checks++; if (got !== lit[i]) $display("FAIL ovf_literal[%0d] got=%h exp=%h", i, got, lit[i]); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [W+2:0] got, exp, now;
    int lat;
    bit rdy;
    bus0.out_ready = 1'b0;
    issue(16'hFFFF, 16'h0001, 1'b0);
    collect(1'b0, got, lat, rdy);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL stall_result got=%h exp=%h", got, exp); else n_pass++;
    n_checks++; if (got !== {16'h0000, 3'b101}) $display("FAIL stall_literal got=%h exp=%h", got, {16'h0000, 3'b101}); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      bus0.in_valid = 1'b1;
      bus0.a   = W'($urandom_range(0, 16'hFFFF));
      bus0.b   = W'($urandom_range(0, 16'hFFFF));
      bus0.sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      now = {bus0.s, bus0.c_out, bus0.ovf, bus0.zero};
      n_checks++; if (bus0.out_valid !== 1'b1 || bus0.in_ready !== 1'b0)
        $display("FAIL stall_hs[%0d] got=%b%b exp=10", i, bus0.out_valid, bus0.in_ready); else n_pass++;
      n_checks++; if (now !== exp) $display("FAIL stall_hold[%0d] got=%h exp=%h", i, now, exp); else n_pass++;
    end
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus0.in_ready !== 1'b1 || bus0.out_valid !== 1'b0)
      $display("FAIL stall_release got=%b%b exp=10", bus0.in_ready, bus0.out_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if (state0 !== 2'd0) $display("FAIL stall_no_accept got=%0d exp=0", state0); else n_pass++;
  endtask

  task automatic test_operand_churn();
    logic [W+2:0] got, exp;
    int lat;
    bit rdy;
    issue(16'h00F0, 16'h0010, 1'b0);
    collect(1'b1, got, lat, rdy);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL churn_result got=%h exp=%h", got, exp); else n_pass++;
    n_checks++; if (got !== {16'h0100, 3'b000}) $display("FAIL churn_literal got=%h exp=%h", got, {16'h0100, 3'b000}); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [W+2:0] got, exp;
    int lat;
    bit rdy;
    issue(16'hABCD, 16'h1111, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    // The aborted operation never produces a result.
    exp_q.delete();
    n_checks++; if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1)
      $display("FAIL midreset_hs got=%b%b exp=01", bus0.out_valid, bus0.in_ready); else n_pass++;
    n_checks++; if ({bus0.s, bus0.c_out, bus0.ovf, bus0.zero} !== '0)
      $display("FAIL midreset_outputs got=%h exp=0", {bus0.s, bus0.c_out, bus0.ovf, bus0.zero}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0003, 16'h0001, 1'b1);
    collect(1'b0, got, lat, rdy);
    exp = exp_q.pop_front();
    n_checks++; if (got !== exp) $display("FAIL midreset_after got=%h exp=%h", got, exp); else n_pass++;
    n_checks++; if (got !== {16'h0002, 3'b100}) $display("FAIL midreset_literal got=%h exp=%h", got, {16'h0002, 3'b100}); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W+2:0] got, exp;
    logic [W-1:0] ra, rb;
    int lat;
    bit rdy;
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom_range(0, 16'hFFFF));
      rb = (i == 0) ? ra : W'($urandom_range(0, 16'hFFFF));
      issue(ra, rb, 1'($urandom_range(0, 1)));
      if (i > 0) begin
        n_checks++; if (last_acc - prev_acc !== 64'd60)
          $display("FAIL b2b_interval[%0d] got=%0d exp=60", i, last_acc - prev_acc); else n_pass++;
      end
      collect(1'b0, got, lat, rdy);
      exp = exp_q.pop_front();
      n_checks++; if (got !== exp) $display("FAIL b2b_result[%0d] got=%h exp=%h", i, got, exp); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_nslice1();
    logic [W-1:0] va[6] = '{16'h1234, 16'h0000, 16'h0005, 16'h7FFF, 16'h8000, 16'hFFFF};
    logic [W-1:0] vb[6] = '{16'h0FFF, 16'h0002, 16'h0005, 16'h0001, 16'h0001, 16'h0001};
    logic         vs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [W+2:0] got, exp;
    int lat;
    for (int i = 0; i < 6; i++) begin
      bus1.a = va[i]; bus1.b = vb[i]; bus1.sub = vs[i]; bus1.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.in_valid = 1'b0;
      exp_q.push_back(model(va[i], vb[i], vs[i]));
      lat = 0;
      while (bus1.out_valid !== 1'b1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      got = {bus1.s, bus1.c_out, bus1.ovf, bus1.zero};
      exp = exp_q.pop_front();
      n_checks++; if (lat !== 1) $display("FAIL n1_latency[%0d] got=%0d exp=1", i, lat); else n_pass++;
      n_checks++; if (got !== exp) $display("FAIL n1_result[%0d] got=%h exp=%h", i, got, exp); else n_pass++;
      @(negedge clk);
      n_checks++; if (bus1.in_ready !== 1'b1) $display("FAIL n1_idle[%0d] got=%b exp=1", i, bus1.in_ready); else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_stall();
    test_operand_churn();
    test_reset_mid();
    test_back_to_back();
    test_nslice1();
    n_checks++; if (exp_q.size() != 0) $display("FAIL leftover_expected got=%0d exp=0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout time=%0t", $time);
    $fatal(1);
  end

endmodule
